i9_7980xe: RTL and testbench



---
 rtl/i9_7980xe.sv | 175 +++++++++++++++++
 tb/tb_i9_7980xe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i9_7980xe.sv
// i9_7980xe: FPGA top of a 16-bit, 3-stage (IF/EX/WB) teaching core with
// instruction ROM, data RAM, WB->EX forwarding, branch flush, and an
// LED / multiplexed seven-segment status display.
module i9_7980xe #(
    parameter string IMEM_FILE = "imem.hex",
    parameter int    DMEM_AW   = 8,
    parameter int    SCAN_DIV  = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [2:0]  pro_reset,
    input  logic [11:0] in_addr,
    input  logic        choose,
    output logic [15:0] leds,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);
    localparam int SCW = SCAN_DIV + 3;

    logic [15:0] imem [4096];
    logic [15:0] dmem [2**DMEM_AW];

    // Memory images: ROM and data RAM power up cleared.
    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = '0;
        for (int i = 0; i < 2**DMEM_AW; i++) dmem[i] = '0;
    end

    logic [11:0]      pc, ifex_pc;
    logic [15:0]      ifex_ins;
    logic             halted;
    logic             wb_we, wb_load;
    logic [2:0]       wb_rd;
    logic [15:0]      wb_alu, ram_q, wb_val;
    logic [7:0][15:0] regs;
    logic [31:0]      cyc;
    logic [SCW-1:0]   scan;

    // EX-stage field decode
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] imm6, imm9;
    assign op     = ifex_ins[15:12];
    assign rd     = ifex_ins[11:9];
    assign rs     = ifex_ins[8:6];
    assign rt     = ifex_ins[5:3];
    assign imm6   = {{10{ifex_ins[5]}}, ifex_ins[5:0]};
    assign imm9   = {{7{ifex_ins[8]}}, ifex_ins[8:0]};
    assign wb_val = wb_load ? ram_q : wb_alu;

    // Operand read with WB forwarding; covers ALU-use and load-use, so no stalls.
    logic [15:0] v_rd, v_rs, v_rt;
    always_comb begin
        v_rd = regs[rd];
        v_rs = regs[rs];
        v_rt = regs[rt];
        if (wb_we && wb_rd == rd) v_rd = wb_val;
        if (wb_we && wb_rd == rs) v_rs = wb_val;
        if (wb_we && wb_rd == rt) v_rt = wb_val;
        if (rd == 3'd0) v_rd = '0;
        if (rs == 3'd0) v_rs = '0;
        if (rt == 3'd0) v_rt = '0;
    end

    logic               ex_we, ex_load, ex_st, ex_br, ex_halt;
    logic [15:0]        ex_res;
    logic [11:0]        ex_tgt;
    logic [DMEM_AW-1:0] ex_addr;
    assign ex_addr = DMEM_AW'(v_rs + imm6);

    // Execute: ALU result, memory intent, branch/jump and halt decisions.
    always_comb begin
        ex_we   = 1'b0;
        ex_load = 1'b0;
        ex_st   = 1'b0;
        ex_br   = 1'b0;
        ex_halt = 1'b0;
        ex_res  = '0;
        ex_tgt  = ifex_pc + 12'd1 + imm6[11:0];
        case (op)
            4'h1: begin ex_we = 1'b1; ex_res = v_rs + v_rt; end
            4'h2: begin ex_we = 1'b1; ex_res = v_rs - v_rt; end
            4'h3: begin ex_we = 1'b1; ex_res = v_rs & v_rt; end
            4'h4: begin ex_we = 1'b1; ex_res = v_rs | v_rt; end
            4'h5: begin ex_we = 1'b1; ex_res = v_rs + imm6; end
            4'h6: begin ex_we = 1'b1; ex_res = imm9; end
            4'h7: begin ex_we = 1'b1; ex_load = 1'b1; end
            4'h8: ex_st = 1'b1;
            4'h9: ex_br = (v_rd == v_rs);
            4'hA: begin ex_br = 1'b1; ex_tgt = ifex_ins[11:0]; end
            4'hF: ex_halt = 1'b1;
            default: ;
        endcase
        if (rd == 3'd0) ex_we = 1'b0;
    end

    // Data RAM main port: SW commits at end of EX, LW read registered into WB.
    always_ff @(posedge clk) begin
        if (ex_st && !pro_reset[0]) dmem[ex_addr] <= v_rd;
        ram_q <= dmem[ex_addr];
    end

    // Pipeline registers, register file, halt flag and cycle counter.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pc       <= '0;
            ifex_ins <= '0;
            ifex_pc  <= '0;
            wb_we    <= 1'b0;
            wb_load  <= 1'b0;
            wb_rd    <= '0;
            wb_alu   <= '0;
            regs     <= '0;
            halted   <= 1'b0;
            cyc      <= '0;
        end else if (pro_reset[0]) begin
            pc       <= {pro_reset[2:1], 10'b0};
            ifex_ins <= '0;
            ifex_pc  <= '0;
            wb_we    <= 1'b0;
            wb_load  <= 1'b0;
            wb_rd    <= '0;
            wb_alu   <= '0;
            regs     <= '0;
            halted   <= 1'b0;
            cyc      <= '0;
        end else begin
            if (wb_we) regs[wb_rd] <= wb_val;
            if (!halted) cyc <= cyc + 32'd1;
            wb_we    <= ex_we;
            wb_load  <= ex_load;
            wb_rd    <= rd;
            wb_alu   <= ex_res;
            ifex_ins <= '0;
            if (halted) begin
                // idle: PC frozen, only bubbles enter EX
            end else if (ex_halt) begin
                halted <= 1'b1;
            end else if (ex_br) begin
                pc <= ex_tgt;
            end else begin
                ifex_ins <= imem[pc];
                ifex_pc  <= pc;
                pc       <= pc + 12'd1;
            end
        end
    end

    // Free-running digit scan counter; top three bits pick the digit.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) scan <= '0;
        else     scan <= scan + SCW'(1);
    end

    logic [15:0] mview;
    logic [31:0] disp;
    logic [2:0]  dig;
    logic [3:0]  nib;
    assign mview = dmem[in_addr[DMEM_AW-1:0]];
    assign disp  = choose ? {4'h0, in_addr, mview} : cyc;
    assign leds  = choose ? mview : {halted, 3'b000, pc};
    assign dig   = scan[SCW-1:SCAN_DIV];
    assign nib   = disp[{dig, 2'b00} +: 4];
    assign AN    = ~(8'b1 << dig);

    // Hex nibble to active-low segments, dp held off.
    always_comb begin
        case (nib)
            4'h0: SEG = 8'hC0;  4'h1: SEG = 8'hF9;  4'h2: SEG = 8'hA4;  4'h3: SEG = 8'hB0;
            4'h4: SEG = 8'h99;  4'h5: SEG = 8'h92;  4'h6: SEG = 8'h82;  4'h7: SEG = 8'hF8;
            4'h8: SEG = 8'h80;  4'h9: SEG = 8'h90;  4'hA: SEG = 8'h88;  4'hB: SEG = 8'h83;
            4'hC: SEG = 8'hC6;  4'hD: SEG = 8'hA1;  4'hE: SEG = 8'h86;  default: SEG = 8'h8E;
        endcase
    end
endmodule

// File: tb/tb_i9_7980xe.sv
// Bench for i9_7980xe: directed programs plus random programs compared
// against an instruction-level (unpipelined) reference interpreter.
module tb_i9_7980xe;
    logic        clk = 1'b0;
    logic        RST;
    logic [2:0]  pro_reset;
    logic [11:0] in_addr;
    logic        choose;
    logic [15:0] leds;
    logic [7:0]  SEG, AN;

    int checks = 0;
    int passed = 0;

    logic [15:0] m_mem [256];
    logic [15:0] prog [$];
    logic [7:0]  segtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          nopops [5] = '{0, 11, 12, 13, 14};

    i9_7980xe #(.IMEM_FILE(""), .DMEM_AW(8), .SCAN_DIV(2)) dut (
        .clk(clk), .RST(RST), .pro_reset(pro_reset), .in_addr(in_addr),
        .choose(choose), .leds(leds), .SEG(SEG), .AN(AN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
        return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 3'(rd), 3'(rs), 6'(imm)};
    endfunction

    function automatic logic [15:0] enc_li(input int rd, input int imm);
        return {4'h6, 3'(rd), 9'(imm)};
    endfunction

    // Architectural interpreter: one instruction per step, no pipeline.
    function automatic void model_run(input logic [11:0] base, output int n_exec,
                                      output int n_taken, output logic [11:0] hpc);
        logic [15:0] r [8];
        logic [11:0] pc, nxt;
        logic [15:0] ins, s6;
        logic [7:0]  ea;
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt;
        int          idx;
        for (int i = 0; i < 8; i++) r[i] = '0;
        pc = base; n_exec = 0; n_taken = 0; hpc = '0;
        for (int step = 0; step < 4000; step++) begin
            idx = int'(pc) - int'(base);
            ins = (idx >= 0 && idx < prog.size()) ? prog[idx] : 16'h0000;
            n_exec++;
            op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
            s6 = {{10{ins[5]}}, ins[5:0]};
            ea = 8'(r[rs] + s6);
            nxt = pc + 12'd1;
            case (op)
                4'h1: r[rd] = r[rs] + r[rt];
                4'h2: r[rd] = r[rs] - r[rt];
                4'h3: r[rd] = r[rs] & r[rt];
                4'h4: r[rd] = r[rs] | r[rt];
                4'h5: r[rd] = r[rs] + s6;
                4'h6: r[rd] = {{7{ins[8]}}, ins[8:0]};
                4'h7: r[rd] = m_mem[ea];
                4'h8: m_mem[ea] = r[rd];
                4'h9: if (r[rd] == r[rs]) begin nxt = pc + 12'd1 + s6[11:0]; n_taken++; end
                4'hA: begin nxt = ins[11:0]; n_taken++; end
                4'hF: begin hpc = pc + 12'd1; return; end
                default: ;
            endcase
            r[0] = '0;
            pc = nxt;
        end
    endfunction

    task automatic read_disp(output logic [31:0] v);
        logic [7:0] seen;
        logic [7:0] onecold;
        seen = '0; v = '0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                onecold = ~(8'd1 << k);
                if (AN == onecold) begin
                    for (int n = 0; n < 16; n++)
                        if (SEG == segtab[n]) begin v[4*k +: 4] = 4'(n); seen[k] = 1'b1; end
                end
            end
        end
        chk("digit scan coverage", {24'h0, seen}, 32'hFF);
    endtask

    task automatic chk_mem(input int a);
        choose = 1'b1; in_addr = 12'(a); #1;
        chk($sformatf("mem[%0d]", a), {16'h0, leds}, {16'h0, m_mem[a]});
        choose = 1'b0; #1;
    endtask

    task automatic run_prog(input string tag, input logic [11:0] base, input int hold);
        int          ne, nt;
        logic [11:0] hpc;
        logic [31:0] cnt;
        bit          ok;
        @(negedge clk);
        choose = 1'b0;
        pro_reset = {base[11:10], 1'b1};
        for (int i = 0; i < prog.size(); i++) dut.imem[int'(base) + i] = prog[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " restart pc"}, {16'h0, leds}, {20'h0, base});
            chk({tag, " restart cnt"}, {24'h0, SEG}, 32'hC0);
        end
        pro_reset = {base[11:10], 1'b0};
        model_run(base, ne, nt, hpc);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = leds[15];
        end
        chk({tag, " halt reached"}, {31'h0, ok}, 32'h1);
        chk({tag, " halted leds"}, {16'h0, leds}, {16'h0, 1'b1, 3'b000, hpc});
        read_disp(cnt);
        chk({tag, " cycle count"}, cnt, 32'(ne + nt + 1));
    endtask

    task automatic gen_random();
        int n, k, rd, rs, rt;
        prog.delete();
        n = $urandom_range(16, 8);
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(9, 0);
            rd = $urandom_range(7, 0);
            rs = $urandom_range(7, 0);
            rt = $urandom_range(7, 0);
            case (k)
                0, 1, 2, 3: prog.push_back(enc_r(k + 1, rd, rs, rt));
                4: prog.push_back(enc_i(5, rd, rs, $urandom_range(63, 0)));
                5: prog.push_back(enc_li(rd, $urandom_range(511, 0)));
                6: prog.push_back(enc_i(7, rd, ($urandom_range(1, 0) == 1) ? 0 : rs, $urandom_range(31, 0)));
                7: prog.push_back(enc_i(8, rd, ($urandom_range(1, 0) == 1) ? 0 : rs, $urandom_range(31, 0)));
                8: prog.push_back(enc_i(9, rd, ($urandom_range(1, 0) == 1) ? rd : rs, $urandom_range(2, 0)));
                default: prog.push_back({4'(nopops[$urandom_range(4, 0)]), 12'($urandom)});
            endcase
        end
        for (int r = 1; r < 8; r++) prog.push_back(enc_i(8, r, 0, 39 + r));
        prog.push_back(16'hF000);
    endtask

    initial begin
        logic [7:0]  an_exp;
        logic [11:0] base;
        bit          ok;
        RST = 1'b1; pro_reset = 3'b000; in_addr = '0; choose = 1'b0;
        for (int a = 0; a < 256; a++) m_mem[a] = '0;
        #1;
        for (int a = 0; a < 4096; a++) dut.imem[a] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset leds", {16'h0, leds}, 32'h0);
        chk("reset AN", {24'h0, AN}, 32'hFE);
        chk("reset SEG", {24'h0, SEG}, 32'hC0);

        // Free run over NOPs: PC counts per clock, scan advances every 4 clocks
        RST = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            an_exp = ~(8'd1 << ((k / 4) % 8));
            chk("nop run pc", {16'h0, leds}, 32'(k));
            chk("scan AN", {24'h0, AN}, {24'h0, an_exp});
        end

        // Back-to-back forwarding
        prog = '{16'h6205, 16'h6403, 16'h1650, 16'h8600, 16'hF000};
        run_prog("fwd", 12'h000, 1);
        chk("fwd pc frozen", {16'h0, leds}, 32'h8005);
        chk_mem(0);
        choose = 1'b1; in_addr = 12'h000; #1;
        chk("fwd M0 const", {16'h0, leds}, 32'h0008);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (AN == 8'hFE);
        end
        chk("digit0 reached", {31'h0, ok}, 32'h1);
        chk("digit0 SEG", {24'h0, SEG}, 32'h80);
        choose = 1'b0;

        // Load-use
        prog = '{enc_li(1, 7), enc_i(8, 1, 0, 2), enc_i(7, 2, 0, 2), enc_i(5, 3, 2, 1),
                 enc_i(8, 3, 0, 3), 16'hF000};
        run_prog("loaduse", 12'h000, 1);
        chk_mem(2);
        choose = 1'b1; in_addr = 12'h003; #1;
        chk("loaduse M3 const", {16'h0, leds}, 32'h0008);
        choose = 1'b0;

        // Branch flush
        prog = '{enc_li(1, 1), enc_i(9, 0, 0, 1), enc_li(1, 9), enc_i(8, 1, 0, 4), 16'hF000};
        run_prog("flush", 12'h000, 2);
        choose = 1'b1; in_addr = 12'h004; #1;
        chk("flush M4 const", {16'h0, leds}, 32'h0001);
        choose = 1'b0;

        // Soft restart into 0x400, then random programs across the bases
        for (int p = 0; p < 7; p++) begin
            gen_random();
            base = (p == 0) ? 12'h400 : {2'($urandom_range(3, 0)), 10'h000};
            run_prog($sformatf("rand%0d", p), base, (p == 0) ? 1 : $urandom_range(3, 1));
            for (int a = 40; a < 47; a++) chk_mem(a);
            for (int j = 0; j < 3; j++) chk_mem($urandom_range(63, 0));
        end

        // Async reset mid-cycle: outputs clear at once, RAM is retained
        @(negedge clk);
        #2 RST = 1'b1;
        #1;
        chk("async rst leds", {16'h0, leds}, 32'h0);
        chk("async rst AN", {24'h0, AN}, 32'hFE);
        chk_mem(40);
        chk_mem(0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
